// File: rtl/stream_fork_pkg.sv
// Shared types and default widths for the round-robin stream fork.
package stream_fork_pkg;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    function automatic port_idx_t other_port(input port_idx_t p);
        return port_idx_t'(~p);
    endfunction

endpackage

// File: rtl/fork_slot.sv
// One-entry output register slice: holds a beat until the consumer takes it.
module fork_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic              can_acc
);

    logic              full_r;
    logic [DATA_W-1:0] data_r;

    // A drain and a load in the same cycle keep the slot full with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            full_r <= 1'b1;
            data_r <= load_data;
        end else if (full_r && out_ready) begin
            full_r <= 1'b0;
        end
    end

    assign full    = full_r;
    assign data    = data_r;
    assign can_acc = !full_r || out_ready;

endmodule

// File: rtl/stream_fork_rr.sv
// Round-robin fork of one valid/ready stream onto two buffered output ports.
// Define STREAM_FORK_RR_WORKCONS_EN to let a stalled port be skipped.
module stream_fork_rr
    import stream_fork_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    port_idx_t        ptr_r;
    port_idx_t        tgt_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [1:0]       can_acc_s;
    logic [1:0]       load_s;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Target selection and input readiness; never depends on in_valid.
    always_comb begin
        tgt_s      = ptr_r;
        in_ready_s = 1'b0;
`ifdef STREAM_FORK_RR_WORKCONS_EN
        if (can_acc_s[ptr_r]) begin
            tgt_s = ptr_r;
        end else begin
            tgt_s = other_port(ptr_r);
        end
        in_ready_s = can_acc_s[0] || can_acc_s[1];
`else
        tgt_s      = ptr_r;
        in_ready_s = can_acc_s[ptr_r];
`endif
    end

    assign accept_s  = in_valid && in_ready_s;
    assign load_s[0] = accept_s && (tgt_s == PORT0);
    assign load_s[1] = accept_s && (tgt_s == PORT1);

    fork_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s[0]),
        .load_data (in_data),
        .out_ready (out0_ready),
        .full      (out0_valid),
        .data      (out0_data),
        .can_acc   (can_acc_s[0])
    );

    fork_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s[1]),
        .load_data (in_data),
        .out_ready (out1_ready),
        .full      (out1_valid),
        .data      (out1_data),
        .can_acc   (can_acc_s[1])
    );

    // Pointer advances past the actual target only on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= PORT0;
        end else if (accept_s) begin
            ptr_r <= other_port(tgt_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Per-port accepted-beat counters; wrap silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (load_s[0]) begin
                cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (load_s[1]) begin
                cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready = in_ready_s;
    assign cnt0     = cnt0_r;
    assign cnt1     = cnt1_r;

endmodule
